// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_gen: parametrised VGA raster timing with look-ahead pixel        |
// | requests, selectable sync polarity and a built-in test-pattern generator.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  pattern_sel,
  input  logic [15:0]                 in_rgb,
  output logic                        pix_req,
  output logic [$clog2(H_ACTIVE)-1:0] pix_x,
  output logic [$clog2(V_ACTIVE)-1:0] pix_y,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        de,
  output logic [15:0]                 out_rgb,
  output logic                        frame_start
);

  localparam int c_H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int c_V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int c_H_START = H_SYNC + H_BACK;
  localparam int c_V_START = V_SYNC + V_BACK;
  localparam int c_HW      = $clog2(c_H_TOTAL);
  localparam int c_VW      = $clog2(c_V_TOTAL);
  localparam int c_HX      = c_HW + 1;
  localparam int c_VX      = c_VW + 1;
  localparam int c_XW      = $clog2(H_ACTIVE);
  localparam int c_YW      = $clog2(V_ACTIVE);
  localparam int c_BAR_W   = H_ACTIVE / 8;
  localparam int c_BW      = (c_BAR_W > 1) ? $clog2(c_BAR_W) : 1;

  localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_HX-1:0] c_H_SYNC_E = c_HX'(H_SYNC);
  localparam logic [c_HX-1:0] c_H_BEG_E  = c_HX'(c_H_START);
  localparam logic [c_HX-1:0] c_H_END_E  = c_HX'(c_H_START + H_ACTIVE);
  localparam logic [c_HX-1:0] c_LEAD_E   = c_HX'(REQ_LEAD);
  localparam logic [c_VX-1:0] c_V_SYNC_E = c_VX'(V_SYNC);
  localparam logic [c_VX-1:0] c_V_BEG_E  = c_VX'(c_V_START);
  localparam logic [c_VX-1:0] c_V_END_E  = c_VX'(c_V_START + V_ACTIVE);
  localparam logic [c_BW-1:0] c_BAR_LAST = c_BW'(c_BAR_W - 1);

  // The look-ahead must never reach back across the previous line.
  generate
    if ((c_H_START <= REQ_LEAD) || (REQ_LEAD < 0) || (REQ_LEAD > 2) ||
        ((H_ACTIVE % 8) != 0)) begin : g_bad_cfg
      $error("vga_timing_gen: illegal timing configuration");
    end
  endgenerate

  logic [c_HW-1:0] r_h_cnt;
  logic [c_VW-1:0] r_v_cnt;
  logic [1:0]      r_pat;
  logic [c_BW-1:0] r_bar_pos;
  logic [2:0]      r_bar_idx;

  logic [c_HX-1:0] w_h_ext;
  logic [c_HX-1:0] w_h_lead;
  logic [c_VX-1:0] w_v_ext;
  logic            w_act;
  logic            w_req;
  logic            w_origin;
  logic [3:0]      w_grid_x;
  logic [3:0]      w_grid_y;
  logic [15:0]     w_pix;

  function automatic logic f_act(input logic [c_HX-1:0] h, input logic [c_VX-1:0] v);
    return (h >= c_H_BEG_E) && (h < c_H_END_E) && (v >= c_V_BEG_E) && (v < c_V_END_E);
  endfunction

  function automatic logic [15:0] f_bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  assign w_h_ext  = {1'b0, r_h_cnt};
  assign w_v_ext  = {1'b0, r_v_cnt};
  assign w_h_lead = w_h_ext + c_LEAD_E;
  assign w_act    = f_act(w_h_ext, w_v_ext);
  assign w_req    = f_act(w_h_lead, w_v_ext);
  assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_grid_x = 4'(w_h_ext - c_H_BEG_E);
  assign w_grid_y = 4'(w_v_ext - c_V_BEG_E);

  assign pix_req = w_req;
  assign pix_x   = w_req ? c_XW'(w_h_lead - c_H_BEG_E) : '0;
  assign pix_y   = w_req ? c_YW'(w_v_ext - c_V_BEG_E) : '0;

  always_comb begin
    w_pix = 16'h0000;
    case (r_pat)
      2'd0:    w_pix = in_rgb;
      2'd1:    w_pix = f_bar_colour(r_bar_idx);
      2'd2:    w_pix = 16'hFFFF;
      default: w_pix = ((w_grid_x == 4'd0) || (w_grid_y == 4'd0)) ? 16'hFFFF : 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == c_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Bar position tracks the pixel at the current h_cnt; blanking reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bar_pos <= '0;
      r_bar_idx <= '0;
    end else if (!w_act) begin
      r_bar_pos <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_pos == c_BAR_LAST) begin
      r_bar_pos <= '0;
      r_bar_idx <= r_bar_idx + 1'b1;
    end else begin
      r_bar_pos <= r_bar_pos + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat       <= 2'd0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      out_rgb     <= 16'h0000;
      frame_start <= 1'b0;
    end else begin
      if (w_origin) r_pat <= pattern_sel;
      hsync       <= (w_h_ext < c_H_SYNC_E) ? HS_POL : ~HS_POL;
      vsync       <= (w_v_ext < c_V_SYNC_E) ? VS_POL : ~VS_POL;
      de          <= w_act;
      out_rgb     <= w_act ? w_pix : 16'h0000;
      frame_start <= w_origin;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_timing_gen: four timing configurations checked against a raster     |
// | model computed from the elapsed cycle count.  Revision: 1.0                 |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

  typedef struct {
    int hs, hb, ha, hf, vs, vb, va, vf;
    bit hpol, vpol;
    int lead;
  } cfg_t;

  typedef struct {
    logic        hs, vs, de, fs, req;
    logic [15:0] rgb;
    int          px, py;
  } exp_t;

  typedef struct {
    int          k;
    logic        hs, vs, de, fs;
    logic [15:0] rgb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] pattern_sel = 2'd3;
  logic       chk_en = 1'b0;
  int         n_err = 0;
  int         n_checks = 0;

  always #5 clk = ~clk;

  // Instances 0..2 share one raster with REQ_LEAD 0/1/2; instance 3 is the tiny grid setup.
  function automatic cfg_t get_cfg(input int i);
    cfg_t c;
    if (i == 3) c = '{2, 2, 8, 2, 1, 1, 2, 1, 1'b1, 1'b1, 1};
    else        c = '{4, 3, 32, 2, 2, 2, 6, 1, 1'b0, 1'b0, i};
    return c;
  endfunction

  function automatic int frame_len(input cfg_t c);
    return (c.hs + c.hb + c.ha + c.hf) * (c.vs + c.vb + c.va + c.vf);
  endfunction

  logic        pr0, pr1, pr2, pr3;
  logic [4:0]  px0, px1, px2;
  logic [2:0]  py0, py1, py2, px3;
  logic [0:0]  py3;
  logic        hs0, hs1, hs2, hs3, vs0, vs1, vs2, vs3;
  logic        de0, de1, de2, de3, fs0, fs1, fs2, fs3;
  logic [15:0] rgb0, rgb1, rgb2, rgb3, in0, in1, in2, in3;
  logic [15:0] q1, q2a, q2b, q3;

  // Source returns {y, x} of the requested pixel after REQ_LEAD cycles.
  assign in0 = {5'(py0), 11'(px0)};
  assign in1 = q1;
  assign in2 = q2b;
  assign in3 = q3;
  always @(posedge clk) begin
    q1  <= {5'(py1), 11'(px1)};
    q2a <= {5'(py2), 11'(px2)};
    q2b <= q2a;
    q3  <= {5'(py3), 11'(px3)};
  end

  vga_timing_gen #(.H_SYNC(4), .H_BACK(3), .H_ACTIVE(32), .H_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(0)) u_d0 (
    .clk(clk), .rst(rst), .pattern_sel(pattern_sel), .in_rgb(in0), .pix_req(pr0), .pix_x(px0),
    .pix_y(py0), .hsync(hs0), .vsync(vs0), .de(de0), .out_rgb(rgb0), .frame_start(fs0));
  vga_timing_gen #(.H_SYNC(4), .H_BACK(3), .H_ACTIVE(32), .H_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(1)) u_d1 (
    .clk(clk), .rst(rst), .pattern_sel(pattern_sel), .in_rgb(in1), .pix_req(pr1), .pix_x(px1),
    .pix_y(py1), .hsync(hs1), .vsync(vs1), .de(de1), .out_rgb(rgb1), .frame_start(fs1));
  vga_timing_gen #(.H_SYNC(4), .H_BACK(3), .H_ACTIVE(32), .H_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(2)) u_d2 (
    .clk(clk), .rst(rst), .pattern_sel(pattern_sel), .in_rgb(in2), .pix_req(pr2), .pix_x(px2),
    .pix_y(py2), .hsync(hs2), .vsync(vs2), .de(de2), .out_rgb(rgb2), .frame_start(fs2));
  vga_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2), .V_SYNC(1), .V_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(1)) u_d3 (
    .clk(clk), .rst(rst), .pattern_sel(pattern_sel), .in_rgb(in3), .pix_req(pr3), .pix_x(px3),
    .pix_y(py3), .hsync(hs3), .vsync(vs3), .de(de3), .out_rgb(rgb3), .frame_start(fs3));

  // Reference state: cycles elapsed since reset plus the pattern chosen at each frame origin.
  int         t_m[4];
  logic [1:0] pat_m[4];
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        t_m[i]   <= 0;
        pat_m[i] <= 2'd0;
      end else begin
        if ((t_m[i] % frame_len(get_cfg(i))) == 0) pat_m[i] <= pattern_sel;
        t_m[i] <= t_m[i] + 1;
      end
    end
  end

  function automatic logic in_act(input cfg_t c, input int h, input int v);
    return (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.ha) &&
           (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.va);
  endfunction

  function automatic logic [15:0] colour(input cfg_t c, input logic [1:0] pat, input int x, input int y);
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    case (pat)
      2'd0:    return {yv[4:0], xv[10:0]};
      2'd1:    return bars[x / (c.ha / 8)];
      2'd2:    return 16'hFFFF;
      default: return ((x % 16 == 0) || (y % 16 == 0)) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  function automatic exp_t model(input cfg_t c, input int t, input logic [1:0] pat);
    exp_t e;
    int   ht = c.hs + c.hb + c.ha + c.hf;
    int   vt = c.vs + c.vb + c.va + c.vf;
    int   p, h, v, hc, vc;
    e.hs  = !c.hpol;
    e.vs  = !c.vpol;
    e.de  = 1'b0;
    e.fs  = 1'b0;
    e.rgb = 16'h0000;
    if (t > 0) begin
      p = t - 1;
      h = p % ht;
      v = (p / ht) % vt;
      e.hs = (h < c.hs) ? c.hpol : !c.hpol;
      e.vs = (v < c.vs) ? c.vpol : !c.vpol;
      e.de = in_act(c, h, v);
      e.fs = (h == 0) && (v == 0);
      if (e.de) e.rgb = colour(c, pat, h - c.hs - c.hb, v - c.vs - c.vb);
    end
    hc    = t % ht;
    vc    = (t / ht) % vt;
    e.req = in_act(c, hc + c.lead, vc);
    e.px  = e.req ? hc + c.lead - c.hs - c.hb : 0;
    e.py  = e.req ? vc - c.vs - c.vb : 0;
    return e;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, inst, $time, got, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic hs, input logic vs, input logic de, input logic fs,
                            input logic [15:0] rgb, input logic req, input logic [31:0] px,
                            input logic [31:0] py);
    exp_t e;
    e = model(get_cfg(i), t_m[i], pat_m[i]);
    chk("hsync", i, 32'(hs), 32'(e.hs));
    chk("vsync", i, 32'(vs), 32'(e.vs));
    chk("de", i, 32'(de), 32'(e.de));
    chk("frame_start", i, 32'(fs), 32'(e.fs));
    chk("out_rgb", i, 32'(rgb), 32'(e.rgb));
    chk("pix_req", i, 32'(req), 32'(e.req));
    chk("pix_x", i, px, e.px);
    chk("pix_y", i, py, e.py);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, hs0, vs0, de0, fs0, rgb0, pr0, 32'(px0), 32'(py0));
      check_inst(1, hs1, vs1, de1, fs1, rgb1, pr1, 32'(px1), 32'(py1));
      check_inst(2, hs2, vs2, de2, fs2, rgb2, pr2, 32'(px2), 32'(py2));
      check_inst(3, hs3, vs3, de3, fs3, rgb3, pr3, 32'(px3), 32'(py3));
    end
  end

  initial begin
    vec_t tbl[11];
    int   edges = 0;
    int   de_cnt = 0;
    int   fs_cnt = 0;

    // Tiny raster (period 14, frame 70), grid pattern, active-high syncs.
    tbl[0]  = '{1,  1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
    tbl[1]  = '{3,  1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{15, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{33, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF};
    tbl[4]  = '{36, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF};
    tbl[5]  = '{47, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF};
    tbl[6]  = '{48, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[7]  = '{53, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[8]  = '{54, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[9]  = '{55, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[10] = '{71, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    for (int j = 0; j < 11; j++) begin
      while (edges < tbl[j].k) begin
        @(posedge clk);
        edges++;
      end
      #1;
      chk("tbl_hsync", j, 32'(hs3), 32'(tbl[j].hs));
      chk("tbl_vsync", j, 32'(vs3), 32'(tbl[j].vs));
      chk("tbl_de", j, 32'(de3), 32'(tbl[j].de));
      chk("tbl_frame_start", j, 32'(fs3), 32'(tbl[j].fs));
      chk("tbl_out_rgb", j, 32'(rgb3), 32'(tbl[j].rgb));
    end

    // One full frame of the mid-size raster: 32x6 visible pixels, a single frame_start.
    for (int c = 0; c < 451; c++) begin
      @(posedge clk);
      #1;
      de_cnt += int'(de1);
      fs_cnt += int'(fs1);
    end
    chk("de_per_frame", 1, de_cnt, 192);
    chk("fs_per_frame", 1, fs_cnt, 1);

    // Asynchronous reset mid-frame: outputs must change before any clock edge.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_hsync", 1, 32'(hs1), 32'd1);
    chk("async_vsync", 1, 32'(vs1), 32'd1);
    chk("async_de", 1, 32'(de1), 32'd0);
    chk("async_rgb", 1, 32'(rgb1), 32'd0);
    chk("async_req", 2, 32'(pr2), 32'd0);
    chk("async_hsync", 3, 32'(hs3), 32'd0);
    chk("async_vsync", 3, 32'(vs3), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_hsync", 1, 32'(hs1), 32'd0);
    chk("rel_frame_start", 1, 32'(fs1), 32'd1);
    chk("rel_hsync", 3, 32'(hs3), 32'd1);

    // Pass-through then colour bars over full frames, then random selections and resets.
    pattern_sel = 2'd0;
    repeat (1000) @(posedge clk);
    #2 pattern_sel = 2'd1;
    repeat (1000) @(posedge clk);
    for (int s = 0; s < 40; s++) begin
      int len;
      int chg;
      len = int'($urandom_range(100, 900));
      chg = int'($urandom_range(0, 99));
      for (int c = 0; c < len; c++) begin
        @(posedge clk);
        if (c == chg) #2 pattern_sel = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #($urandom_range(1, 4)) rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
